// File: rtl/mult_div.sv
// Iterative MIPS multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with internal HI/LO registers and direct MTHI/MTLO writes.
module mult_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_a_md,
    input  logic [WIDTH-1:0] in_b_md,
    input  logic [1:0]       op_md,
    input  logic             start_md,
    input  logic             wr_hi_md,
    input  logic             wr_lo_md,
    output logic             busy_md,
    output logic             done_md,
    output logic [WIDTH-1:0] out_hi_md,
    output logic [WIDTH-1:0] out_lo_md
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             neg_a, neg_b;
    logic [WIDTH-1:0] a_raw, mag_a, mag_b;
    logic [WIDTH-1:0] acc_hi, acc_lo;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             done_q;

    logic             sgn_a_in, sgn_b_in;
    logic [WIDTH-1:0] mag_a_in, mag_b_in;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [2*WIDTH-1:0] prod, prod_neg;
    logic [WIDTH-1:0] fix_hi, fix_lo;

    assign busy_md   = (state != IDLE);
    assign done_md   = done_q;
    assign out_hi_md = hi_q;
    assign out_lo_md = lo_q;

    // op_md[0] set means unsigned, so no sign is extracted.
    always_comb begin
        sgn_a_in = ~op_md[0] & in_a_md[WIDTH-1];
        sgn_b_in = ~op_md[0] & in_b_md[WIDTH-1];
        mag_a_in = sgn_a_in ? -in_a_md : in_a_md;
        mag_b_in = sgn_b_in ? -in_b_md : in_b_md;
    end

    // One iteration: multiply shifts the 2W accumulator right, divide shifts left.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_a} : {(WIDTH + 1){1'b0}});
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, mag_b};
        div_diff  = div_shift[WIDTH-1:0] - mag_b;
        if (is_div) begin
            step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_neg = -prod;
        if (is_div) begin
            if (mag_b == '0) begin
                fix_lo = '1;
                fix_hi = a_raw;
            end else begin
                fix_lo = (neg_a ^ neg_b) ? -acc_lo : acc_lo;
                fix_hi = neg_a ? -acc_hi : acc_hi;
            end
        end else if (neg_a ^ neg_b) begin
            fix_hi = prod_neg[2*WIDTH-1:WIDTH];
            fix_lo = prod_neg[WIDTH-1:0];
        end else begin
            fix_hi = acc_hi;
            fix_lo = acc_lo;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            a_raw  <= '0;
            mag_a  <= '0;
            mag_b  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == FIX);
            case (state)
                IDLE: begin
                    if (start_md) begin
                        state  <= CALC;
                        cnt    <= '0;
                        is_div <= op_md[1];
                        neg_a  <= sgn_a_in;
                        neg_b  <= sgn_b_in;
                        a_raw  <= in_a_md;
                        mag_a  <= mag_a_in;
                        mag_b  <= mag_b_in;
                        acc_hi <= '0;
                        acc_lo <= op_md[1] ? mag_a_in : mag_b_in;
                    end else begin
                        if (wr_hi_md) hi_q <= in_a_md;
                        if (wr_lo_md) lo_q <= in_a_md;
                    end
                end
                CALC: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= FIX;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    hi_q  <= fix_hi;
                    lo_q  <= fix_lo;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div.sv
// Scoreboard bench for mult_div: stimulus pushes expected HI/LO, a monitor
// checks every done_md pulse for value, latency and busy duration.
module tb_mult_div;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_a_md = '0;
    logic [31:0] in_b_md = '0;
    logic [1:0]  op_md = '0;
    logic        start_md = 1'b0;
    logic        wr_hi_md = 1'b0;
    logic        wr_lo_md = 1'b0;
    logic        busy_md, done_md;
    logic [31:0] out_hi_md, out_lo_md;

    mult_div #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_a_md  (in_a_md),
        .in_b_md  (in_b_md),
        .op_md    (op_md),
        .start_md (start_md),
        .wr_hi_md (wr_hi_md),
        .wr_lo_md (wr_lo_md),
        .busy_md  (busy_md),
        .done_md  (done_md),
        .out_hi_md(out_hi_md),
        .out_lo_md(out_lo_md)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   busy_cnt = 0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy_cnt = 0;
        end else begin
            if (busy_md) busy_cnt++;
            if (done_md) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, "_hi"}, out_hi_md, e.hi);
                    check({e.name, "_lo"}, out_lo_md, e.lo);
                    check({e.name, "_latency"}, 32'(cyc - e.cyc), 32'd34);
                    check({e.name, "_busy_cycles"}, 32'(busy_cnt), 32'd33);
                end
                busy_cnt = 0;
            end
        end
    end

    // Drive one start cycle; optionally with direct-write strobes alongside.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input string name,
                         input bit push, input bit with_wr);
        exp_t e;
        @(negedge clk);
        op_md = op; in_a_md = a; in_b_md = b; start_md = 1'b1;
        wr_hi_md = with_wr; wr_lo_md = with_wr;
        e.hi = ehi; e.lo = elo; e.cyc = cyc; e.name = name;
        if (push) exp_q.push_back(e);
        @(negedge clk);
        start_md = 1'b0; wr_hi_md = 1'b0; wr_lo_md = 1'b0;
    endtask

    // mode 0: quiet, 1: toggle operands, 2: extra start mid-op, 3: direct write mid-op
    task automatic wait_done(input int mode, input string name);
        bit seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (done_md) begin
                seen = 1;
            end else begin
                if (mode == 1) begin
                    in_a_md = $urandom; in_b_md = $urandom;
                end
                if (mode == 2 && i == 10) begin
                    op_md = 2'b00; in_a_md = 32'd9; in_b_md = 32'd9; start_md = 1'b1;
                end
                if (mode == 3 && i == 10) begin
                    in_a_md = 32'hDEADBEEF; wr_hi_md = 1'b1; wr_lo_md = 1'b1;
                end
                @(negedge clk);
                start_md = 1'b0; wr_hi_md = 1'b0; wr_lo_md = 1'b0;
                if (mode == 3 && i == 10) begin
                    check("busy_write_hi", out_hi_md, 32'h12345678);
                    check("busy_write_lo", out_lo_md, 32'h12345678);
                end
            end
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no done in 60 cycles, expected done", name);
        end
    endtask

    initial begin
        #23;
        check("reset_busy", 32'(busy_md), 32'd0);
        check("reset_done", 32'(done_md), 32'd0);
        check("reset_hi", out_hi_md, 32'd0);
        check("reset_lo", out_lo_md, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        issue(2'b00, -32'sd3, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult_neg3x5", 1, 0);
        wait_done(0, "mult_neg3x5");
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max", 1, 0);
        wait_done(1, "multu_max");
        issue(2'b00, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, "mult_7xneg1", 1, 0);
        wait_done(0, "mult_7xneg1");
        issue(2'b10, -32'sd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7by2", 1, 0);
        wait_done(0, "div_neg7by2");
        issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, "div_ovf", 1, 0);
        wait_done(0, "div_ovf");
        issue(2'b11, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF, "divu_by0", 1, 0);
        wait_done(2, "divu_by0");
        issue(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100by7", 1, 0);
        wait_done(0, "divu_100by7");
        issue(2'b10, -32'sd5, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, "div_neg5by0", 1, 0);
        wait_done(0, "div_neg5by0");

        // Direct write in IDLE.
        @(negedge clk);
        in_a_md = 32'h12345678; wr_hi_md = 1'b1; wr_lo_md = 1'b1;
        @(negedge clk);
        wr_hi_md = 1'b0; wr_lo_md = 1'b0;
        check("idle_write_hi", out_hi_md, 32'h12345678);
        check("idle_write_lo", out_lo_md, 32'h12345678);

        // Write while busy is ignored; result still lands.
        issue(2'b00, 32'd2, 32'd3, 32'd0, 32'd6, "mult_2x3", 1, 0);
        wait_done(3, "mult_2x3");

        // Write alongside start is discarded.
        issue(2'b01, 32'h12345678, 32'd2, 32'd0, 32'h2468ACF0, "start_wr", 1, 1);
        check("start_wr_busy", 32'(busy_md), 32'd1);
        check("start_wr_lo_held", out_lo_md, 32'd6);
        wait_done(0, "start_wr");

        // Reset mid-CALC aborts with no done.
        issue(2'b01, 32'd3, 32'd3, 32'd0, 32'd9, "aborted", 0, 0);
        repeat (8) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy_md), 32'd0);
        check("midrst_done", 32'(done_md), 32'd0);
        check("midrst_hi", out_hi_md, 32'd0);
        check("midrst_lo", out_lo_md, 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        issue(2'b01, 32'd3, 32'd4, 32'd0, 32'd12, "after_rst", 1, 0);
        wait_done(0, "after_rst");

        repeat (40) @(negedge clk);
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL pending_results: got %0d outstanding, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mult_div.md
# mult_div

Iterative multiply/divide unit for the MIPS execute stage. It runs MULT, MULTU, DIV and DIVU over a fixed number of cycles and holds the results in internal HI/LO registers. It also supports direct HI/LO writes (MTHI/MTLO). The HI/LO outputs feed the writeback select mux that serves MFHI/MFLO; the controller stalls on `busy_md`.

## Interface

- `WIDTH`, default 32: operand width; also the number of iteration cycles.
- `clk` in, 1 bit: single clock; all state updates on the rising edge.
- `rst` in, 1 bit: reset, asynchronous and active-high.
- `in_a_md` in, WIDTH bits: operand A (multiplicand / dividend); MTHI/MTLO write data.
- `in_b_md` in, WIDTH bits: operand B (multiplier / divisor).
- `op_md` in, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `start_md` in, 1 bit: begin operation `op_md` on the current operands.
- `wr_hi_md` in, 1 bit: write `in_a_md` into HI.
- `wr_lo_md` in, 1 bit: write `in_a_md` into LO.
- `busy_md` out, 1 bit: operation in progress.
- `done_md` out, 1 bit: one-cycle pulse; HI/LO hold the new result.
- `out_hi_md` out, WIDTH bits: HI register (product upper half / remainder).
- `out_lo_md` out, WIDTH bits: LO register (product lower half / quotient).

## Operation

- States are IDLE, CALC and FIX.
  - IDLE → CALC when `start_md`=1.
  - CALC → FIX after WIDTH iterations; an iteration counter runs 0..WIDTH-1.
  - FIX → IDLE unconditionally.
- `busy_md` = (state != IDLE). Derived from the state register only.
- On start, the unit latches `op_md` and operands internally. For signed ops it captures magnitudes plus two sign bits. Input changes while busy have no effect.
- Multiply: shift-add over the magnitudes into a 2·WIDTH accumulator, one bit per CALC cycle. In FIX, if signed and the signs differ, the 2·WIDTH result is two's-complement negated. HI gets the upper half, LO the lower half.
- Divide: restoring division over the magnitudes, one quotient bit per CALC cycle. In FIX, for signed ops:
  - the quotient is negated if the signs differ;
  - the remainder is negated if the dividend is negative.
  - LO gets the quotient, HI the remainder.
- Signed overflow (DIV 0x80000000 / -1): the quotient truncates to WIDTH bits, so LO=0x80000000 and HI=0. No trap.
- Divide by zero, signed or unsigned: LO=all ones, HI=`in_a_md` as latched. The full latency is still spent.
- MTHI/MTLO (`wr_hi_md`/`wr_lo_md`):
  - take effect only in IDLE with `start_md`=0;
  - both may assert together;
  - are ignored while busy;
  - are discarded when `start_md` is high in the same cycle, because start has priority.
- `start_md` while busy is ignored; it is not queued.
- HI/LO change only on a FIX→IDLE edge or an accepted direct write.

## Timing

- Reset, asynchronous: state=IDLE, counter=0, `busy_md`=0, `done_md`=0, `out_hi_md`=0, `out_lo_md`=0. Reset mid-operation aborts the operation with no HI/LO update and no `done_md`.
- Start sampled at the end of cycle N:
  - CALC during cycles N+1..N+WIDTH;
  - FIX during cycle N+WIDTH+1;
  - IDLE during cycle N+WIDTH+2.
- `busy_md`=1 for cycles N+1..N+WIDTH+1 (WIDTH+1 cycles).
- `done_md`=1 for exactly cycle N+WIDTH+2, a registered pulse. New HI/LO are valid from that cycle onward.
- Total latency from start to done is WIDTH+2 cycles (34 at the default).
- A new start may be sampled in the `done_md` cycle, giving back-to-back operations with one idle cycle.
- Direct write sampled at the end of cycle M: `out_hi_md`/`out_lo_md` show the new value in cycle M+1. No `done_md` for writes.

## Test plan

- **Reset:** assert `rst` mid-CALC → all outputs 0 within the same cycle; after release, a fresh start completes normally.
- **Signed multiply:** MULT -3 × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. Check `done_md` exactly 34 cycles after start, and `busy_md` high for 33 cycles.
- **Unsigned multiply:** MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. Toggle `in_a_md`/`in_b_md` while busy → result unchanged.
- **Signed divide:**
  - DIV -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- **Unsigned divide:** DIVU 100 / 0 → LO=0xFFFFFFFF, HI=0x00000064. Assert `start_md` mid-operation → ignored, one `done_md` only.
- **Direct writes:**
  - `wr_hi_md`+`wr_lo_md` with `in_a_md`=0x12345678 in IDLE → both outputs 0x12345678 the next cycle.
  - The same write while busy → no change.
  - The same write with `start_md` in the same cycle → write discarded, operation runs.
